// File: rtl/rr_dispatcher_pkg.sv
// Shared helpers for the round-robin dispatcher: modular add, lowest-set-bit
// encoder and one-hot decoder, sized for the largest supported port count.
package rr_dispatcher_pkg;

  localparam int MAX_NUM = 16;
  localparam int SEL_W   = 5;   // holds 0..MAX_NUM inclusive
  localparam int ENC_W   = 4;

  // (a + b) mod n for a, b < n; compare-and-subtract so non-power-of-2 n works
  function automatic logic [SEL_W-1:0] mod_add(input logic [SEL_W-1:0] a,
                                                input logic [SEL_W-1:0] b,
                                                input logic [SEL_W-1:0] n);
    logic [SEL_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, n}) s = s - {1'b0, n};
    return s[SEL_W-1:0];
  endfunction

  function automatic logic [ENC_W-1:0] lsb_index(input logic [MAX_NUM-1:0] m);
    logic [ENC_W-1:0] idx;
    idx = '0;
    for (int i = MAX_NUM-1; i >= 0; i--)
      if (m[i]) idx = ENC_W'(i);
    return idx;
  endfunction

  function automatic logic [MAX_NUM-1:0] dec_onehot(input logic [ENC_W-1:0] i);
    return MAX_NUM'(1) << i;
  endfunction

endpackage

// File: rtl/rr_dispatcher_fifo.sv
// Per-port private FIFO: DEPTH entries, power-of-2 wrapping head/tail and an
// explicit occupancy counter so full/empty need no pointer compare.
module dispatch_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [PTR_W-1:0]                 head, tail;
  logic [CNT_W-1:0]                 cnt;
  logic                             do_push, do_pop;

  assign full     = (cnt == CNT_W'(DEPTH));
  assign empty    = (cnt == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign data_out = mem[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem  <= '0;
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      // storage is left as-is; only the bookkeeping is discarded
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) begin
        mem[tail] <= data_in;
        tail      <= tail + PTR_W'(1);
      end
      if (do_pop) head <= head + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/rr_dispatcher.sv
// One-to-NUM round-robin dispatcher: each accepted payload goes to the first
// non-full port at or after the rotating pointer; each port buffers privately.
module rr_dispatcher
  import rr_dispatcher_pkg::*;
#(
  parameter int NUM        = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [DATA_WIDTH-1:0]          data_i,
  output logic [NUM-1:0]                 valid_o,
  input  logic [NUM-1:0]                 ready_i,
  output logic [NUM-1:0][DATA_WIDTH-1:0] data_o
);

  localparam int IDX_W = $clog2(NUM);

  logic [IDX_W-1:0] ptr, off, sel;
  logic [NUM-1:0]   full, empty, not_full, rot, wr_en, rd_en;
  logic             push;

  assign not_full = ~full;

  // Selection sees only registered occupancy, so a full port popping this
  // cycle is still skipped and ready_o never depends on ready_i.
  always_comb begin
    rot = '0;
    for (int k = 0; k < NUM; k++)
      rot[k] = not_full[IDX_W'(mod_add(SEL_W'(ptr), SEL_W'(k), SEL_W'(NUM)))];
    off = IDX_W'(lsb_index(MAX_NUM'(rot)));
    sel = IDX_W'(mod_add(SEL_W'(ptr), SEL_W'(off), SEL_W'(NUM)));
  end

  assign ready_o = (|not_full) & ~flush_i;
  assign push    = valid_i & ready_o;
  assign wr_en   = push ? NUM'(dec_onehot(ENC_W'(sel))) : '0;
  assign rd_en   = ready_i & ~empty;
  assign valid_o = ~empty;

  always_ff @(posedge clk) begin
    if (rst || flush_i)
      ptr <= '0;
    else if (push)
      ptr <= IDX_W'(mod_add(SEL_W'(sel), SEL_W'(1), SEL_W'(NUM)));
  end

  for (genvar i = 0; i < NUM; i++) begin : g_port
    dispatch_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush_i),
      .push     (wr_en[i]),
      .data_in  (data_i),
      .pop      (rd_en[i]),
      .full     (full[i]),
      .empty    (empty[i]),
      .data_out (data_o[i])
    );
  end

endmodule

// File: tb/tb_rr_dispatcher.sv
// Directed + random bench for rr_dispatcher: a NUM=4 and a NUM=3 instance share
// stimulus; per-port scoreboards predict every ready/valid/data observation.
module tb_rr_dispatcher;

  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic                 clk = 1'b0;
  logic                 rst, flush, valid_i;
  logic [DW-1:0]        data_i;
  logic [3:0]           ready_i;

  logic                 a_ready;
  logic [3:0]           a_valid;
  logic [3:0][DW-1:0]   a_data;
  logic                 b_ready;
  logic [2:0]           b_valid;
  logic [2:0][DW-1:0]   b_data;

  rr_dispatcher #(.NUM(4), .DATA_WIDTH(DW), .DEPTH(DEPTH)) u_a (
    .clk(clk), .rst(rst), .flush_i(flush), .valid_i(valid_i), .ready_o(a_ready),
    .data_i(data_i), .valid_o(a_valid), .ready_i(ready_i), .data_o(a_data));

  rr_dispatcher #(.NUM(3), .DATA_WIDTH(DW), .DEPTH(DEPTH)) u_b (
    .clk(clk), .rst(rst), .flush_i(flush), .valid_i(valid_i), .ready_o(b_ready),
    .data_i(data_i), .valid_o(b_valid), .ready_i(ready_i[2:0]), .data_o(b_data));

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] sb [8][$];   // index = dut*4 + port
  int            mptr [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Check outputs at negedge against the model, then advance the model at posedge.
  task automatic cyc();
    @(negedge clk);
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        int         num;
        logic       er;
        logic [3:0] ev;
        num = (d == 0) ? 4 : 3;
        er  = 1'b0;
        ev  = '0;
        for (int p = 0; p < num; p++) begin
          if (sb[d*4+p].size() < DEPTH) er = 1'b1;
          if (sb[d*4+p].size() > 0)     ev[p] = 1'b1;
        end
        er = er & ~flush;
        chk($sformatf("dut%0d ready_o", d), 64'(d == 0 ? a_ready : b_ready), 64'(er));
        chk($sformatf("dut%0d valid_o", d), 64'(d == 0 ? a_valid : {1'b0, b_valid}), 64'(ev));
        for (int p = 0; p < num; p++)
          if (ev[p])
            chk($sformatf("dut%0d data_o[%0d]", d, p),
                64'(d == 0 ? a_data[p] : b_data[p]), 64'(sb[d*4+p][0]));
      end
    end
    @(posedge clk);
    if (rst || flush) begin
      for (int i = 0; i < 8; i++) sb[i].delete();
      mptr[0] = 0;
      mptr[1] = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        int num, sel;
        int sz [4];
        num = (d == 0) ? 4 : 3;
        sel = -1;
        for (int p = 0; p < num; p++) sz[p] = sb[d*4+p].size();
        if (valid_i)
          for (int k = 0; k < num; k++) begin
            int p;
            p = (mptr[d] + k) % num;
            if (sel < 0 && sz[p] < DEPTH) sel = p;
          end
        for (int p = 0; p < num; p++)
          if (sz[p] > 0 && ready_i[p]) void'(sb[d*4+p].pop_front());
        if (sel >= 0) begin
          sb[d*4+sel].push_back(data_i);
          mptr[d] = (sel + 1) % num;
        end
      end
    end
    #1;
  endtask

  task automatic push_n(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      valid_i = 1'b1;
      data_i  = base + DW'(i);
      cyc();
    end
    valid_i = 1'b0;
  endtask

  task automatic idle_n(input int n);
    valid_i = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; valid_i = 1'b0; data_i = '0; ready_i = 4'hf;
    mptr[0] = 0; mptr[1] = 0;

    // reset state, including cleared storage
    do_reset();
    for (int p = 0; p < 4; p++) chk($sformatf("reset a_data[%0d]", p), 64'(a_data[p]), 64'd0);
    for (int p = 0; p < 3; p++) chk($sformatf("reset b_data[%0d]", p), 64'(b_data[p]), 64'd0);

    // streaming with all consumers ready
    ready_i = 4'hf;
    push_n(5, 32'h10);
    idle_n(3);

    // port 1 blocked: fills, then skipped
    ready_i = 4'b1101;
    push_n(8, 32'h20);
    ready_i = 4'hf;
    idle_n(4);

    // fill everything, full port popping, single-port release
    do_reset();
    ready_i = 4'h0;
    push_n(8, 32'h30);
    valid_i = 1'b1; data_i = 32'h40; ready_i = 4'b0001; cyc();
    valid_i = 1'b1; data_i = 32'h41; ready_i = 4'b0000; cyc();
    idle_n(1);
    ready_i = 4'b0100; idle_n(1);
    ready_i = 4'b0000;
    valid_i = 1'b1; data_i = 32'h42; cyc();
    idle_n(1);
    ready_i = 4'hf;
    idle_n(6);

    // flush with a push request in the same cycle
    ready_i = 4'h0;
    push_n(3, 32'h50);
    flush = 1'b1; valid_i = 1'b1; data_i = 32'h5f; cyc();
    flush = 1'b0; idle_n(1);
    push_n(1, 32'h60);
    ready_i = 4'hf;
    idle_n(2);

    // random consumer back-pressure
    for (int i = 0; i < 200; i++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      data_i  = $urandom;
      ready_i = 4'($urandom_range(0, 15));
      cyc();
    end
    ready_i = 4'hf;
    idle_n(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rr_dispatcher.md
Name: rr_dispatcher

Overview:
- Takes one valid/ready input stream and spreads it across NUM output ports in round-robin order; it is the distributing end that pairs with the many-to-one arbiters.
- Each output port has a small private FIFO, so one stalled consumer never blocks the others.
- Sits between a single producer (e.g. a rename/dispatch stage) and NUM parallel consumers (issue queues, MSHR-like slots).
- Internally it decodes the target index to a one-hot write enable and priority-encodes the rotated "not full" mask.

Parameters:
NUM, 4, number of output ports (2..16)
DATA_WIDTH, 32, payload width in bits
DEPTH, 2, entries per output FIFO (power of 2, >= 2)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
flush_i  input  1  drop all buffered entries and reset the round-robin pointer
valid_i  input  1  input payload valid
ready_o  output  1  dispatcher can accept this cycle
data_i  input  DATA_WIDTH  input payload
valid_o  output  NUM  per-port output valid
ready_i  input  NUM  per-port consumer ready
data_o  output  NUM x DATA_WIDTH  per-port payload (packed array, index = port)

Behaviour:
Interface facts:
- One clock, clk.
- Reset rst is synchronous and active-high.
- All state updates on the rising edge of clk.

Reset (rst=1 at an edge):
- ptr=0.
- All FIFO head/tail/count = 0.
- Storage cleared to 0.
- Next cycle: valid_o=0, data_o=0, ready_o=1.

Per-port FIFO i:
- count_i ranges 0..DEPTH.
- full_i = (count_i == DEPTH); empty_i = (count_i == 0).
- valid_o[i] = ~empty_i.
- data_o[i] = head entry. It is 0 after reset or flush until first written; otherwise don't-care while invalid.

Target selection (combinational from registered state only):
- Rotate ~full by ptr.
- Priority-encode lowest set bit; sel = (ptr + offset) mod NUM.
- ready_o = (|~full) & ~flush_i.
- ready_o must not depend on ready_i; there is no combinational valid_i->ready_o or ready_i->ready_o path.

Push:
- Condition: valid_i & ready_o.
- data_i is written to the tail of FIFO sel.
- ptr <= (sel + 1) mod NUM.
- If no push, ptr holds.

Pop:
- Condition: valid_o[i] & ready_i[i], per port independently.
- Head advances, count_i decrements.

Simultaneous push and pop on the same port:
- count unchanged; both pointers advance.
- A port full at the start of the cycle is never selected, even if it is popping that cycle.

Latency:
- Accepted payload appears on valid_o[sel] at the next cycle at the earliest.
- FIFO order is preserved per port.

Wrap-around:
- head/tail are log2(DEPTH) bits and wrap naturally.
- ptr wraps from NUM-1 to 0.
- For non-power-of-2 NUM, wrap uses compare-and-clear, not bit truncation.

All ports full:
- ready_o=0; ptr holds.

flush_i:
- Highest priority after rst.
- At the edge: all counts/pointers=0 and ptr=0; push and pops in that cycle are discarded.
- ready_o=0 during the flush cycle.
- Storage need not be cleared on flush.

rst mid-operation:
- Overrides everything; buffered data is lost.

Decomposition:
- Shared utils package: no new typedefs needed. Port index width IDX_W = $clog2(NUM) and pointer width $clog2(DEPTH) are local parameters.
- Selection logic uses the existing priority encoders and decoders; for generic NUM it uses a generate-loop equivalent.
- One sub-module: dispatch_fifo, with parameters DATA_WIDTH and DEPTH and ports clk, rst, flush, push, data_in, pop, full, empty, data_out. It is instantiated NUM times via generate.

Test Plan:
1. Reset then stream, NUM=4, all ready_i=1: rst 1 cycle, then valid_i=1 with data 0x10,0x11,0x12,0x13,0x14 on consecutive cycles -> ports 0,1,2,3,0 receive them in order; each payload appears one cycle after acceptance; ready_o stays 1.
2. Blocked port skip: ready_i=4'b1101 for 8 pushes (DEPTH=2) -> port 1 fills with 2 entries; afterwards selection skips port 1 and rotates 2,3,0,2,...; port 1 outputs nothing while blocked.
3. All full: ready_i=0, push 8 items -> ready_o=0 after the 8th accept and ptr frozen. Then raise ready_i[2] for 1 cycle -> ready_o=1 the following cycle, and the next push goes to port 2.
4. Full port popping same cycle: port 0 full with ready_i[0]=1, ptr=0, all other ports full -> ready_o=0 that cycle (no push into a popping full port); the push is accepted the next cycle into port 0.
5. Flush mid-stream: 3 items buffered, assert flush_i together with valid_i=1 -> ready_o=0, nothing accepted; next cycle valid_o=0, ptr=0, and the next push goes to port 0.
6. Per-port ordering and wrap: NUM=3, DEPTH=2, random ready_i over 200 cycles against a scoreboard -> per-port FIFO order preserved, no loss or duplication, ptr wraps 2->0.
